// File: rtl/f3_gpu_pkg.sv
// Shared constants and types for the f3_gpu image-viewer stage.
package f3_gpu_pkg;

  localparam logic [2:0] INS_NONE       = 3'd0;
  localparam logic [2:0] INS_PREV       = 3'd1;
  localparam logic [2:0] INS_NEXT       = 3'd2;
  localparam logic [2:0] INS_ROT        = 3'd3;
  localparam logic [2:0] INS_NEG        = 3'd4;
  localparam logic [2:0] INS_MIRROR     = 3'd5;
  localparam logic [2:0] INS_RESET_VIEW = 3'd6;

  typedef enum logic {ST_IDLE, ST_ANIM} state_e;

  typedef enum logic {DIR_FWD, DIR_REV} dir_e;

  localparam logic [1:0] ROT_0   = 2'd0;
  localparam logic [1:0] ROT_90  = 2'd1;
  localparam logic [1:0] ROT_180 = 2'd2;
  localparam logic [1:0] ROT_270 = 2'd3;

endpackage

// File: rtl/f3_gpu_if.sv
// Pixel/command bus between the VGA address side, the mapper/ROM and the GPU stage.
interface f3_gpu_if #(
  parameter int unsigned COORD_W    = 11,
  parameter int unsigned COLOR_W    = 3,
  parameter int unsigned IMG_BITS   = 4,
  parameter int unsigned NUM_IMAGES = 8
);
  localparam int unsigned IDX_W = $clog2(NUM_IMAGES);

  logic [2:0]           instruction;
  logic [2*COORD_W-1:0] display_addr;
  logic [COLOR_W-1:0]   pixel_data;
  logic [IMG_BITS-1:0]  mapper_pixel_x;
  logic [IMG_BITS-1:0]  mapper_pixel_y;
  logic [2*COORD_W-1:0] mapper_display_addr;
  logic [2*IMG_BITS-1:0] pixel_addr;
  logic [IDX_W-1:0]     image_index;
  logic [COLOR_W-1:0]   display_data;
  logic                 busy;

  modport master (
    output instruction, display_addr, pixel_data, mapper_pixel_x, mapper_pixel_y,
    input  mapper_display_addr, pixel_addr, image_index, display_data, busy
  );

  modport slave (
    input  instruction, display_addr, pixel_data, mapper_pixel_x, mapper_pixel_y,
    output mapper_display_addr, pixel_addr, image_index, display_data, busy
  );

endinterface

// File: rtl/f3_addr_xform.sv
// Combinational mirror + rotation of an image coordinate into a ROM pixel address.
module f3_addr_xform
  import f3_gpu_pkg::*;
#(
  parameter int unsigned IMG_BITS = 4
) (
  input  logic [IMG_BITS-1:0]   pix_x,
  input  logic [IMG_BITS-1:0]   pix_y,
  input  logic [1:0]            rot,
  input  logic                  mirror,
  output logic [2*IMG_BITS-1:0] pixel_addr
);

  localparam logic [IMG_BITS-1:0] M = '1;

  logic [IMG_BITS-1:0] x;
  logic [IMG_BITS-1:0] y;

  always_comb begin
    x = mirror ? (M - pix_x) : pix_x;
    y = pix_y;
    unique case (rot)
      ROT_0:   pixel_addr = {y, x};
      ROT_90:  pixel_addr = {x, M - y};
      ROT_180: pixel_addr = {M - y, M - x};
      ROT_270: pixel_addr = {M - x, y};
      default: pixel_addr = {y, x};
    endcase
  end

endmodule

// File: rtl/f3_gpu.sv
// Image-viewer GPU stage: address transform, command FSM and windowed colour output.
// Optional wipe transition between images is enabled with F3_GPU_ANIM_EN.
module f3_gpu
  import f3_gpu_pkg::*;
#(
  parameter int unsigned COORD_W    = 11,
  parameter int unsigned COLOR_W    = 3,
  parameter int unsigned IMG_BITS   = 4,
  parameter int unsigned NUM_IMAGES = 8,
  parameter int unsigned WIN_X0     = 231,
  parameter int unsigned WIN_X1     = 711,
  parameter int unsigned WIN_Y0     = 36,
  parameter int unsigned WIN_Y1     = 516,
  parameter int unsigned ANIM_DIV   = 16
) (
  input logic      sysclk,
  input logic      rst,
  f3_gpu_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(NUM_IMAGES);
  localparam int unsigned AW    = 2 * IMG_BITS;
  localparam logic [IDX_W-1:0] LAST_IMG = IDX_W'(NUM_IMAGES - 1);

  logic [IDX_W-1:0]   cur_img;
  logic [1:0]         rot;
  logic               mirror;
  logic               negative;
  logic               armed;
  logic [COLOR_W-1:0] display_data_q;
  logic [AW-1:0]      pixel_addr;
  logic               idle;
  logic               accept;
  logic [IDX_W-1:0]   img_inc;
  logic [IDX_W-1:0]   img_dec;

`ifdef F3_GPU_ANIM_EN
  localparam int unsigned DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(ANIM_DIV - 1);
  localparam logic [AW:0]      WIPE_LAST = (AW+1)'((1 << AW) - 1);
  localparam logic [AW:0]      WIPE_FULL = (AW+1)'(1 << AW);

  state_e           state;
  dir_e             dir;
  logic [IDX_W-1:0] prev_img;
  logic [AW:0]      wipe_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             busy_q;

  assign idle     = (state == ST_IDLE);
  assign bus.busy = busy_q;
`else
  assign idle     = 1'b1;
  assign bus.busy = 1'b0;
`endif

  assign accept  = armed && (bus.instruction != INS_NONE) && idle;
  assign img_inc = (cur_img == LAST_IMG) ? '0 : cur_img + 1'b1;
  assign img_dec = (cur_img == '0) ? LAST_IMG : cur_img - 1'b1;

  // Any cycle with instruction==0 re-arms, so a held code acts exactly once.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      cur_img  <= '0;
      rot      <= ROT_0;
      mirror   <= 1'b0;
      negative <= 1'b0;
      armed    <= 1'b1;
`ifdef F3_GPU_ANIM_EN
      state    <= ST_IDLE;
      dir      <= DIR_FWD;
      prev_img <= '0;
      wipe_cnt <= '0;
      div_cnt  <= '0;
      busy_q   <= 1'b0;
`endif
    end else begin
      armed <= (bus.instruction == INS_NONE);
      if (accept) begin
        case (bus.instruction)
          INS_NEXT, INS_PREV: begin
            cur_img  <= (bus.instruction == INS_NEXT) ? img_inc : img_dec;
            rot      <= ROT_0;
            mirror   <= 1'b0;
            negative <= 1'b0;
`ifdef F3_GPU_ANIM_EN
            prev_img <= cur_img;
            dir      <= (bus.instruction == INS_NEXT) ? DIR_FWD : DIR_REV;
            wipe_cnt <= '0;
            div_cnt  <= '0;
            state    <= ST_ANIM;
            busy_q   <= 1'b1;
`endif
          end
          INS_ROT:    rot      <= rot + 2'd1;
          INS_NEG:    negative <= ~negative;
          INS_MIRROR: mirror   <= ~mirror;
          INS_RESET_VIEW: begin
            rot      <= ROT_0;
            mirror   <= 1'b0;
            negative <= 1'b0;
          end
          default: ;
        endcase
      end
`ifdef F3_GPU_ANIM_EN
      else if (state == ST_ANIM) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          // Leave on the step that would reach 2**AW; wipe_cnt never holds it.
          if (wipe_cnt == WIPE_LAST) begin
            wipe_cnt <= '0;
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
          end else begin
            wipe_cnt <= wipe_cnt + 1'b1;
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
`endif
    end
  end

  f3_addr_xform #(
    .IMG_BITS (IMG_BITS)
  ) u_xform (
    .pix_x      (bus.mapper_pixel_x),
    .pix_y      (bus.mapper_pixel_y),
    .rot        (rot),
    .mirror     (mirror),
    .pixel_addr (pixel_addr)
  );

  always_comb begin
    bus.image_index = cur_img;
`ifdef F3_GPU_ANIM_EN
    if (state == ST_ANIM) begin
      if (dir == DIR_FWD) begin
        if ({1'b0, pixel_addr} >= wipe_cnt) bus.image_index = prev_img;
      end else begin
        if ({1'b0, pixel_addr} < (WIPE_FULL - wipe_cnt)) bus.image_index = prev_img;
      end
    end
`endif
  end

  logic [COORD_W-1:0] disp_x;
  logic [COORD_W-1:0] disp_y;
  logic               outside;

  assign disp_x  = bus.display_addr[2*COORD_W-1:COORD_W];
  assign disp_y  = bus.display_addr[COORD_W-1:0];
  assign outside = (disp_x < COORD_W'(WIN_X0)) || (disp_x > COORD_W'(WIN_X1)) ||
                   (disp_y < COORD_W'(WIN_Y0)) || (disp_y > COORD_W'(WIN_Y1));

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      display_data_q <= '0;
    end else begin
      display_data_q <= outside ? '0 : (negative ? ~bus.pixel_data : bus.pixel_data);
    end
  end

  assign bus.display_data        = display_data_q;
  assign bus.pixel_addr          = pixel_addr;
  assign bus.mapper_display_addr = bus.display_addr;

endmodule

// File: tb/tb_f3_gpu.sv
// Directed bench for f3_gpu; display outputs are checked through an expected-value queue.
module tb_f3_gpu;

  localparam int unsigned COORD_W    = 11;
  localparam int unsigned COLOR_W    = 3;
  localparam int unsigned IMG_BITS   = 4;
  localparam int unsigned NUM_IMAGES = 8;
  localparam int unsigned ANIM_DIV   = 2;
  localparam int unsigned WIPE_CYC   = ANIM_DIV * (1 << (2 * IMG_BITS));

  logic sysclk;
  logic rst;
  int   compared;
  int   mismatched;
  int   n;
  logic [COLOR_W-1:0] exp_q[$];

  f3_gpu_if #(
    .COORD_W    (COORD_W),
    .COLOR_W    (COLOR_W),
    .IMG_BITS   (IMG_BITS),
    .NUM_IMAGES (NUM_IMAGES)
  ) bus ();

  f3_gpu #(
    .COORD_W    (COORD_W),
    .COLOR_W    (COLOR_W),
    .IMG_BITS   (IMG_BITS),
    .NUM_IMAGES (NUM_IMAGES),
    .WIN_X0     (231),
    .WIN_X1     (711),
    .WIN_Y0     (36),
    .WIN_Y1     (516),
    .ANIM_DIV   (ANIM_DIV)
  ) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (bus)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_disp(input int x, input int y, input logic [COLOR_W-1:0] pd,
                            input logic [COLOR_W-1:0] exp);
    bus.display_addr = {COORD_W'(x), COORD_W'(y)};
    bus.pixel_data   = pd;
    exp_q.push_back(exp);
    #1;
    chk("mapper_display_addr", 32'(bus.mapper_display_addr), 32'({COORD_W'(x), COORD_W'(y)}));
    tick();
    chk("display_data", 32'(bus.display_data), 32'(exp_q.pop_front()));
  endtask

  task automatic press(input logic [2:0] code);
    bus.instruction = code;
    tick();
    bus.instruction = 3'd0;
    tick();
  endtask

  task automatic xaddr(input int x, input int y);
    bus.mapper_pixel_x = IMG_BITS'(x);
    bus.mapper_pixel_y = IMG_BITS'(y);
    #1;
  endtask

  task automatic wait_idle(inout int cnt);
    while (bus.busy === 1'b1 && cnt < 4 * WIPE_CYC) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {int x; int y; logic [2:0] pd; logic [2:0] exp;} win_t;
  win_t win_tbl[7];

  initial begin
    compared   = 0;
    mismatched = 0;
    win_tbl[0] = '{100, 100, 3'd5, 3'd0};
    win_tbl[1] = '{231, 36, 3'd5, 3'd5};
    win_tbl[2] = '{230, 36, 3'd5, 3'd0};
    win_tbl[3] = '{711, 516, 3'd6, 3'd6};
    win_tbl[4] = '{712, 516, 3'd6, 3'd0};
    win_tbl[5] = '{711, 517, 3'd6, 3'd0};
    win_tbl[6] = '{400, 35, 3'd7, 3'd0};

    rst                = 1'b1;
    bus.instruction    = 3'd0;
    bus.display_addr   = '0;
    bus.pixel_data     = '0;
    bus.mapper_pixel_x = '0;
    bus.mapper_pixel_y = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset mid-frame: output clears asynchronously.
    drive_disp(300, 100, 3'd5, 3'd5);
    rst = 1'b1;
    #1;
    chk("rst_display_data", 32'(bus.display_data), 32'd0);
    chk("rst_image_index", 32'(bus.image_index), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    tick();
    foreach (win_tbl[i]) drive_disp(win_tbl[i].x, win_tbl[i].y, win_tbl[i].pd, win_tbl[i].exp);

    // Next press with timed wipe.
    bus.instruction = 3'd2;
    tick();
    bus.instruction = 3'd0;
`ifdef F3_GPU_ANIM_EN
    chk("next_busy", 32'(bus.busy), 32'd1);
    repeat (20) tick();
    n = 20;
    xaddr(9, 0);
    chk("wipe_fwd_pa9", 32'(bus.image_index), 32'd1);
    xaddr(10, 0);
    chk("wipe_fwd_pa10", 32'(bus.image_index), 32'd0);
    wait_idle(n);
    chk("next_busy_cycles", 32'(n), 32'(WIPE_CYC));
`else
    chk("next_busy", 32'(bus.busy), 32'd0);
`endif
    chk("next_image_index", 32'(bus.image_index), 32'd1);

    // Second press during the wipe must be dropped.
    tick();
    press(3'd2);
    press(3'd2);
    n = 0;
    wait_idle(n);
`ifdef F3_GPU_ANIM_EN
    chk("dropped_press", 32'(bus.image_index), 32'd2);
`else
    chk("dropped_press", 32'(bus.image_index), 32'd3);
`endif

    // Reset in the middle of a wipe.
    press(3'd2);
    repeat (50) tick();
`ifdef F3_GPU_ANIM_EN
    chk("midwipe_busy", 32'(bus.busy), 32'd1);
`endif
    rst = 1'b1;
    #1;
    chk("midwipe_rst_busy", 32'(bus.busy), 32'd0);
    chk("midwipe_rst_image", 32'(bus.image_index), 32'd0);
    rst = 1'b0;
    tick();

    // Prev wraps 0 -> NUM_IMAGES-1; reverse wipe boundary at 256-wipe_cnt.
    bus.instruction = 3'd1;
    tick();
    bus.instruction = 3'd0;
`ifdef F3_GPU_ANIM_EN
    repeat (20) tick();
    n = 20;
    xaddr(5, 15);
    chk("wipe_rev_pa245", 32'(bus.image_index), 32'd0);
    xaddr(6, 15);
    chk("wipe_rev_pa246", 32'(bus.image_index), 32'd7);
    wait_idle(n);
    chk("prev_busy_cycles", 32'(n), 32'(WIPE_CYC));
`endif
    chk("prev_wrap_image", 32'(bus.image_index), 32'(NUM_IMAGES - 1));

    // Rotation: held code acts once, then each press steps rot.
    tick();
    xaddr(2, 5);
    chk("rot0_pa", 32'(bus.pixel_addr), 32'h52);
    bus.instruction = 3'd3;
    repeat (20) tick();
    bus.instruction = 3'd0;
    tick();
    chk("held_rot1_pa", 32'(bus.pixel_addr), 32'h2A);
    press(3'd3);
    chk("rot2_pa", 32'(bus.pixel_addr), 32'hAD);
    press(3'd3);
    chk("rot3_pa", 32'(bus.pixel_addr), 32'hD5);
    press(3'd6);
    chk("reset_view_pa", 32'(bus.pixel_addr), 32'h52);

    // Negative and mirror.
    press(3'd4);
    press(3'd5);
    xaddr(0, 0);
    chk("mirror_pa", 32'(bus.pixel_addr), 32'h0F);
    drive_disp(300, 200, 3'b001, 3'b110);
    drive_disp(230, 200, 3'b001, 3'b000);
    chk("busy_idle_end", 32'(bus.busy), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/f3_gpu.md
Name: f3_gpu

Overview:
Parametrised successor of the image-viewer GPU stage. It sits between the VGA address generator and the image ROM/mapper. It converts display coordinates into image-pixel addresses with rotation, mirror and negative transforms. It also runs a command state machine that switches images with a timed wipe transition, and adds a reset-view command and a busy flag.

Parameters:
COORD_W, 11, width of each display coordinate; display_addr = {x, y}
COLOR_W, 3, pixel colour width
IMG_BITS, 4, image side = 2**IMG_BITS pixels; M = 2**IMG_BITS-1
NUM_IMAGES, 8, number of stored images (>=2); IDX_W = clog2(NUM_IMAGES)
WIN_X0/WIN_X1, 231/711, inclusive horizontal display window
WIN_Y0/WIN_Y1, 36/516, inclusive vertical display window
ANIM_DIV, 16, sysclk cycles per wipe step (>=1)

Ports:
sysclk  in  1  system clock
rst  in  1  asynchronous active-high reset
instruction  in  3  0 none, 1 prev, 2 next, 3 rotate, 4 negative, 5 mirror, 6 reset view, 7 reserved/no-op
display_addr  in  2*COORD_W  current display pixel {x,y}
pixel_data  in  COLOR_W  ROM data for {image_index, pixel_addr}
mapper_pixel_x  in  IMG_BITS  image column from mapper
mapper_pixel_y  in  IMG_BITS  image row from mapper
mapper_display_addr  out  2*COORD_W  = display_addr (combinational)
pixel_addr  out  2*IMG_BITS  transformed ROM pixel address (combinational)
image_index  out  IDX_W  ROM image select (combinational)
display_data  out  COLOR_W  registered output colour
busy  out  1  high while a wipe is running

Behaviour:
- Reset (async, any state): cur_img=0, prev_img=0, rot=0, mirror=0, negative=0, wipe_cnt=0, div_cnt=0, armed=1, FSM=IDLE, display_data=0, busy=0.
- Press handling: a nonzero instruction is accepted only when armed=1 and FSM=IDLE; acceptance clears armed. armed is set again in any cycle in which instruction==0. A held code therefore acts exactly once. Nonzero codes arriving while in ANIM clear armed and are dropped.
- FSM states: IDLE and ANIM.
- IDLE, code 2: prev_img<=cur_img; cur_img<=(cur_img==NUM_IMAGES-1)?0:cur_img+1; rot, mirror, negative <=0; dir<=fwd; wipe_cnt<=0; div_cnt<=0; ->ANIM.
- IDLE, code 1: same as code 2, except cur_img decrements with wrap 0->NUM_IMAGES-1 and dir<=rev.
- IDLE, code 3: rot<=rot+1, mod 4.
- IDLE, code 4: toggle negative.
- IDLE, code 5: toggle mirror.
- IDLE, code 6: rot, mirror, negative <=0. No image change.
- ANIM: div_cnt counts 0..ANIM_DIV-1. On div_cnt==ANIM_DIV-1, wipe_cnt increments. When wipe_cnt reaches 2**(2*IMG_BITS), go to IDLE, wipe_cnt<=0. busy = (FSM==ANIM).
- Address path (combinational):
  - x = mirror ? M-mapper_pixel_x : mapper_pixel_x; y = mapper_pixel_y.
  - rot 0: {y,x}; rot 1: {x,M-y}; rot 2: {M-y,M-x}; rot 3: {M-x,y}.
  - All subtractions are IMG_BITS wide.
- Image select: image_index = cur_img, except in ANIM:
  - fwd: pixel_addr >= wipe_cnt -> prev_img.
  - rev: pixel_addr < 2**(2*IMG_BITS)-wipe_cnt -> prev_img.
  - Comparisons are done at 2*IMG_BITS+1 width.
- Output, one-cycle latency: display_data <= outside window ? 0 : (negative ? ~pixel_data : pixel_data).
  - Outside window means x<WIN_X0 or x>WIN_X1 or y<WIN_Y0 or y>WIN_Y1.
  - The window flag uses the same-cycle display_addr.
  - negative is sampled in the same cycle as the window flag.

Optional Feature:
F3_GPU_ANIM_EN. With it defined: ANIM state and wipe as above. Without it: codes 1/2 update cur_img immediately and stay in IDLE; busy is tied 0; image_index = cur_img always; the div/wipe counters are not built.

Decomposition:
Shared package f3_gpu_pkg:
- instruction code constants: INS_NONE, INS_PREV, INS_NEXT, INS_ROT, INS_NEG, INS_MIRROR, INS_RESET_VIEW.
- FSM state encoding: ST_IDLE, ST_ANIM.
- rotation mode constants.
Natural sub-module: f3_addr_xform, purely combinational mirror + rotation of {x,y} to pixel_addr, parametrised by IMG_BITS.

Test Plan:
- Reset and idle output: assert rst mid-frame, then drive display_addr x=100,y=100 -> display_data=0 next cycle; image_index=0; busy=0.
- Next press with ANIM_DIV=2, IMG_BITS=4:
  - Pulse instruction 2 then 0 -> busy=1 for 512 cycles; image_index 1.
  - At wipe_cnt=10, pixel_addr 9 -> image_index 1; pixel_addr 10 -> image_index 0.
- Prev wrap: from cur_img=0, instruction 1 -> final image_index=NUM_IMAGES-1 (7).
- Held instruction: hold 3 for 20 cycles -> rot=1 only; mapper x=2,y=5 -> pixel_addr=0x2A.
- Negative and mirror: code 4 then 5, mapper x=0,y=0, pixel_data 3'b001 inside window -> pixel_addr=0x0F, display_data=3'b110.
- Reset mid-anim and dropped press: code 2 during ANIM -> ignored. rst asserted mid-wipe -> busy=0, image_index=0 immediately.
